note_sequencer: RTL

- Upstream stage of the audio tone generator. Drives its playSound and 19-bit delay (half-period count) inputs.
- Steps through a small writable song RAM. Each entry is a half-period delay plus a duration in ticks.
- Inserts a silent articulation gap between notes and reports busy/done to game control logic.
- delay output convention: the tone period is 2*(delay+1) CLOCK_50 cycles.

---
 rtl/note_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Song RAM sequencer feeding the tone generator's playSound/delay inputs.
// Optional macro NOTE_SEQUENCER_LOOP_EN: repeat the song until stop instead of a single pass.
module note_sequencer #(
    parameter int NUM_NOTES = 16,
    parameter int ADDR_W    = 4,
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [26:0]       wr_data,
    output logic              playSound,
    output logic [18:0]       delay,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0]  TICK_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_NOTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_ADVANCE, S_DONE
    } state_t;

    state_t state, next;

    logic [26:0]      song_mem [NUM_NOTES];
    logic [26:0]      rd_data;
    logic [7:0]       entry_dur;
    logic [18:0]      entry_delay;
    logic [PRE_W-1:0] presc;
    logic [7:0]       dur_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tick_wrap;
    logic             wrap_now;

    assign entry_dur   = rd_data[26:19];
    assign entry_delay = rd_data[18:0];
    assign tick_wrap   = (presc == TICK_LAST);
    assign busy        = (state != S_IDLE);

    // Song RAM: read port free-runs on note_idx, so FETCH's read is ready in LOAD.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            song_mem[wr_addr] <= wr_data;
        rd_data <= song_mem[note_idx];
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next     = state;
        wrap_now = 1'b0;
        case (state)
            S_IDLE:  if (start) next = S_FETCH;
            S_FETCH: next = S_LOAD;
            S_LOAD: begin
                if (entry_dur == 8'd0) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                    // A marker at entry 0 would spin forever without producing sound.
                    if (note_idx != '0) begin
                        next     = S_FETCH;
                        wrap_now = 1'b1;
                    end else begin
                        next = S_DONE;
                    end
`else
                    next = S_DONE;
`endif
                end else begin
                    next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_wrap && dur_cnt == 8'd1)
                    next = (GAP_TICKS > 0) ? S_GAP : S_ADVANCE;
            end
            S_GAP: begin
                if (tick_wrap && gap_cnt == GAP_W'(1))
                    next = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (note_idx == LAST_IDX) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                    next     = S_FETCH;
                    wrap_now = 1'b1;
`else
                    next = S_DONE;
`endif
                end else begin
                    next = S_FETCH;
                end
            end
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
        if (stop) begin
            next     = S_IDLE;
            wrap_now = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            playSound <= 1'b0;
            delay     <= '0;
            note_idx  <= '0;
            done      <= 1'b0;
            presc     <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= (next == S_DONE) || wrap_now;

            if (state == S_LOAD && next == S_PLAY)
                playSound <= (entry_delay != 19'd0);
            else if (!(state == S_PLAY && next == S_PLAY))
                playSound <= 1'b0;

            // The entry is captured here, so later RAM writes cannot disturb the live note.
            if (state == S_LOAD && next == S_PLAY) begin
                delay   <= entry_delay;
                dur_cnt <= entry_dur;
            end else if (state == S_PLAY && tick_wrap) begin
                dur_cnt <= dur_cnt - 8'd1;
            end

            if (state == S_PLAY && next == S_GAP)
                gap_cnt <= GAP_W'(GAP_TICKS);
            else if (state == S_GAP && tick_wrap)
                gap_cnt <= gap_cnt - GAP_W'(1);

            if ((state == S_PLAY || state == S_GAP) && !tick_wrap)
                presc <= presc + PRE_W'(1);
            else
                presc <= '0;

            if (wrap_now || next == S_IDLE || next == S_DONE)
                note_idx <= '0;
            else if (state == S_ADVANCE)
                note_idx <= note_idx + ADDR_W'(1);
        end
    end

endmodule
